// File: rtl/fft_input_reorder.sv
// Input reorder stage for an 8-point radix-2 DIT FFT: buffers one frame in
// bit-reversed order and issues butterfly operand pairs with the stage-1 twiddle.
module fft_input_reorder #(
    parameter int unsigned NPTS  = 8,
    parameter logic [31:0] W0_RE = 32'h3F800000,
    parameter logic [31:0] W0_IM = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a1,
    output logic [31:0] b1,
    output logic [31:0] a2,
    output logic [31:0] b2,
    output logic [31:0] wr,
    output logic [31:0] wi,
    output logic        out_last
);

    localparam int unsigned IdxW  = $clog2(NPTS);
    localparam int unsigned PairW = IdxW - 1;
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NPTS - 1);
    localparam logic [PairW-1:0] LastPair = PairW'(NPTS / 2 - 1);

    typedef enum logic [0:0] {
        StFill,
        StIssue
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic [PairW-1:0]  pair_q, pair_d;
    logic [63:0]       buf_q [NPTS];
    logic [63:0]       buf_d [NPTS];

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [31:0]       a1_q, a1_d;
    logic [31:0]       b1_q, b1_d;
    logic [31:0]       a2_q, a2_d;
    logic [31:0]       b2_q, b2_d;
    logic [31:0]       wr_q, wr_d;
    logic [31:0]       wi_q, wi_d;

    logic              accept;
    logic              xfer;
    logic [IdxW-1:0]   wr_addr;

    always_comb begin
        for (int unsigned i = 0; i < IdxW; i++) begin
            wr_addr[i] = cnt_q[IdxW-1-i];
        end
    end

    assign accept = (state_q == StFill) && in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        buf_d   = buf_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        a2_d    = a2_q;
        b2_d    = b2_q;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    buf_d[wr_addr] = {in_re, in_im};
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        // Last sample lands this edge, so pair 0 is taken from buf_d.
                        state_d      = StIssue;
                        pair_d       = '0;
                        {a1_d, b1_d} = buf_d[0];
                        {a2_d, b2_d} = buf_d[1];
                    end
                end
            end
            StIssue: begin
                if (xfer) begin
                    if (pair_q == LastPair) begin
                        state_d = StFill;
                        pair_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        pair_d       = pair_q + 1'b1;
                        {a1_d, b1_d} = buf_q[{pair_d, 1'b0}];
                        {a2_d, b2_d} = buf_q[{pair_d, 1'b1}];
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase

        in_ready_d  = (state_d == StFill);
        out_valid_d = (state_d == StIssue);
        out_last_d  = (state_d == StIssue) && (pair_d == LastPair);
        wr_d        = W0_RE;
        wi_d        = W0_IM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            pair_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            a2_q        <= '0;
            b2_q        <= '0;
            wr_q        <= '0;
            wi_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pair_q      <= pair_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            a2_q        <= a2_d;
            b2_q        <= b2_d;
            wr_q        <= wr_d;
            wi_q        <= wi_d;
        end
    end

    // Sample storage needs no reset; a fresh frame overwrites every slot before issue.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign a1        = a1_q;
    assign b1        = b1_q;
    assign a2        = a2_q;
    assign b2        = b2_q;
    assign wr        = wr_q;
    assign wi        = wi_q;

endmodule

// File: tb/tb_fft_input_reorder.sv
// Directed bench for fft_input_reorder: frame ordering, backpressure, gapped
// input, back-to-back frames and asynchronous reset behaviour.
module tb_fft_input_reorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a1, b1, a2, b2, wr, wi;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    // Issue order of original sample indices, hand-derived from bit reversal.
    int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    // IEEE-754 single encodings of 0.0 .. 7.0.
    logic [31:0] fl [8] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    fft_input_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a1        (a1),
        .b1        (b1),
        .a2        (a2),
        .b2        (b2),
        .wr        (wr),
        .wi        (wi),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] smp_re(input logic [7:0] seed, input int i);
        if (seed == 8'h00) return fl[i];
        return {seed, 21'h0, 3'(i)};
    endfunction

    function automatic logic [31:0] smp_im(input logic [7:0] seed, input int i);
        if (seed == 8'h00) return fl[i] | 32'h80000000;
        return ~smp_re(seed, i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from the current cycle; inputs stay valid during issue to
    // show they are ignored. Returns cycles taken until in_ready returns.
    task automatic run_frame(input logic [7:0] seed, input bit gapped, input int stall_pair,
                             input int stall_n, output int cycles);
        int idx = 0;
        int pk = 0;
        int stall = 0;
        int cyc = 0;
        logic [128:0] held = '0;
        while (pk < 4 && cyc < 300) begin
            in_valid  = gapped ? (cyc % 2 == 0) : 1'b1;
            in_re     = (idx < 8) ? smp_re(seed, idx) : 32'hDEADBEEF;
            in_im     = (idx < 8) ? smp_im(seed, idx) : 32'hBADC0DE0;
            out_ready = !(pk == stall_pair && stall < stall_n);
            if (out_valid) begin
                check_eq("in_ready_issue", 64'(in_ready), 64'd0);
                check_eq("wr", 64'(wr), 64'h3F800000);
                check_eq("wi", 64'(wi), 64'h0);
                if (!out_ready) begin
                    if (stall > 0)
                        check_eq("stall_hold", 64'({a1, b1} ^ {a2, b2} ^ 64'(out_last)),
                                 64'(held[128:65] ^ held[64:1] ^ 64'(held[0])));
                    if (stall > 0) check_eq("stall_a1", 64'(a1), 64'(held[128:97]));
                    held = {a1, b1, a2, b2, out_last};
                    stall++;
                end else begin
                    check_eq($sformatf("p%0d_a", pk), {a1, b1},
                             {smp_re(seed, ord[2*pk]), smp_im(seed, ord[2*pk])});
                    check_eq($sformatf("p%0d_b", pk), {a2, b2},
                             {smp_re(seed, ord[2*pk+1]), smp_im(seed, ord[2*pk+1])});
                    check_eq($sformatf("p%0d_last", pk), 64'(out_last), 64'(pk == 3));
                    pk++;
                end
            end else if (idx < 8) begin
                check_eq("in_ready_fill", 64'(in_ready), 64'd1);
            end
            if (in_ready && in_valid && idx < 8) idx++;
            tick();
            cyc++;
        end
        if (pk < 4) check_eq("frame_timeout", 64'(pk), 64'd4);
        check_eq("in_ready_after", 64'(in_ready), 64'd1);
        check_eq("valid_after", 64'(out_valid), 64'd0);
        cycles = cyc;
    endtask

    task automatic pulse_reset();
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_last", 64'(out_last), 64'd0);
        check_eq("rst_ready", 64'(in_ready), 64'd0);
        check_eq("rst_data", {a1, b1 | a2 | b2 | wr | wi}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_eq("ready_post_rst", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int cyc_a;
        int cyc_b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_im     = '0;
        tick();
        tick();
        check_eq("reset_ready", 64'(in_ready), 64'd0);
        check_eq("reset_valid", 64'(out_valid), 64'd0);
        check_eq("reset_wr", 64'(wr), 64'd0);
        rst = 1'b0;
        tick();
        check_eq("ready_first_edge", 64'(in_ready), 64'd1);

        // Float ramp, no backpressure.
        run_frame(8'h00, 1'b0, -1, 0, cyc_a);
        check_eq("frame_cycles", 64'(cyc_a), 64'd12);

        // Five-cycle stall on pair 1.
        run_frame(8'h21, 1'b0, 1, 5, cyc_a);
        check_eq("stall_cycles", 64'(cyc_a), 64'd17);

        // Gapped input.
        run_frame(8'h00, 1'b1, -1, 0, cyc_a);

        // Back-to-back frames.
        run_frame(8'h31, 1'b0, -1, 0, cyc_a);
        run_frame(8'h32, 1'b0, -1, 0, cyc_b);
        check_eq("b2b_period_a", 64'(cyc_a), 64'd12);
        check_eq("b2b_period_b", 64'(cyc_b), 64'd12);

        // Reset after five samples; stale data must not reappear.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_re = smp_re(8'h55, i);
            in_im = smp_im(8'h55, i);
            tick();
        end
        pulse_reset();
        run_frame(8'h66, 1'b0, -1, 0, cyc_a);
        check_eq("fresh_cycles", 64'(cyc_a), 64'd12);

        // Reset while stalled in ISSUE.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_re = smp_re(8'h77, i);
            in_im = smp_im(8'h77, i);
            tick();
        end
        tick();
        check_eq("issue_valid", 64'(out_valid), 64'd1);
        check_eq("issue_pair0", {a1, a2}, {smp_re(8'h77, 0), smp_re(8'h77, 4)});
        pulse_reset();
        in_valid = 1'b0;
        check_eq("post_rst_valid", 64'(out_valid), 64'd0);
        run_frame(8'h88, 1'b0, -1, 0, cyc_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_input_reorder.md
FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

Interface
REQ-001 Parameter: NPTS, 8, FFT length in complex samples; only 8 is supported.
REQ-002 Parameter: W0_RE, 32'h3F800000, real part of the stage-1 twiddle factor (IEEE-754 single 1.0).
REQ-003 Parameter: W0_IM, 32'h00000000, imaginary part of the stage-1 twiddle factor (0.0).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block can accept a sample this cycle.
REQ-008 in_re  in  32  real part of the input sample (IEEE-754 single).
REQ-009 in_im  in  32  imaginary part of the input sample (IEEE-754 single).
REQ-010 out_valid  out  1  butterfly operand set present.
REQ-011 out_ready  in  1  downstream butterfly accepts the operand set this cycle.
REQ-012 a1, b1  out  32 each  real and imaginary parts of the first operand (butterfly top input).
REQ-013 a2, b2  out  32 each  real and imaginary parts of the second operand (butterfly bottom input).
REQ-014 wr, wi  out  32 each  twiddle factor real and imaginary parts.
REQ-015 out_last  out  1  marks the final (4th) operand set of a frame.

Function
REQ-016 The block SHALL run a 2-state FSM, FILL and ISSUE; it SHALL enter FILL on reset.
REQ-017 FILL: in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 FILL: a sample SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-019 FILL: input sample index i (3-bit counter, 0..7) SHALL be stored at buffer address bitrev(i) = {i[0],i[1],i[2]}.
REQ-020 FILL -> ISSUE SHALL occur on the clock edge that accepts sample 7; out_valid SHALL be 1 in the next cycle.
REQ-021 ISSUE: in_ready SHALL be 0; in_valid SHALL be ignored and no sample accepted.
REQ-022 ISSUE: pair k (2-bit counter, 0..3) SHALL present buffer[2k] on a1/b1 and buffer[2k+1] on a2/b2.
REQ-023 The resulting issue order SHALL be (x0,x4), (x2,x6), (x1,x5), (x3,x7).
REQ-024 wr and wi SHALL equal W0_RE and W0_IM whenever out_valid is 1.
REQ-025 A pair SHALL transfer on a cycle where out_valid and out_ready are both 1.
REQ-026 While out_valid=1 and out_ready=0, a1, b1, a2, b2, wr, wi and out_last SHALL hold stable.
REQ-027 out_valid SHALL NOT drop until the pending pair transfers.
REQ-028 out_last SHALL be 1 only while pair 3 is presented.
REQ-029 The transfer of pair 3 SHALL return the FSM to FILL with both counters at 0.
REQ-030 in_ready SHALL be 1 in the cycle after pair 3 transfers; there are no idle cycles between frames.
REQ-031 Steady-state throughput SHALL be 12 cycles per frame when in_valid and out_ready are held at 1: 8 fill cycles + 4 issue cycles.
REQ-032 The block SHALL pass data bit-exactly; it performs no arithmetic on sample values.
REQ-033 The buffer SHALL hold 8 x 64 bits in registers; both counters SHALL wrap modulo their range.

Reset
REQ-034 On assertion of rst, in any state and mid-frame, the block SHALL asynchronously force the FSM to FILL, clear both counters, set out_valid=0 and out_last=0, and set in_ready=0 while rst is high.
REQ-035 During reset, a1, b1, a2, b2, wr and wi SHALL be 0.
REQ-036 Buffer contents SHALL be don't-care after reset; partially loaded frames SHALL be discarded.
REQ-037 On the first clock edge after rst deasserts, in_ready SHALL be 1.

Verification
REQ-038 Scenario: feed in_re = float(i), in_im = -float(i) for i=0..7 with out_ready=1 -> pairs (0,4), (2,6), (1,5), (3,7) on consecutive cycles; out_last=1 only on (3,7); wr=3F800000, wi=0 throughout.
REQ-039 Scenario: hold out_ready=0 for 5 cycles on pair 1 -> outputs frozen at (x2,x6) and in_ready=0; transfer resumes in order when out_ready=1.
REQ-040 Scenario: toggle in_valid 1/0 while feeding 8 samples -> only handshaken samples are stored; output order is identical to REQ-038.
REQ-041 Scenario: two back-to-back frames with in_valid=out_ready=1 -> second frame's first sample is accepted the cycle after the first frame's pair 3; period is 12 cycles.
REQ-042 Scenario: assert rst after 5 samples, then feed a fresh 8-sample frame -> the old samples never appear; output matches the fresh frame.
REQ-043 Scenario: assert rst during ISSUE with out_ready=0 -> out_valid=0 immediately without waiting for a clock edge; in_ready=1 on the first edge after release.
